// File: rtl/scaler_bank_v3.sv
// Gated edge-counting scaler bank: per-channel saturating counters latched into a
// shadow bank on each window close, with an addressed single-cycle read port.
module scaler_bank_v3 #(
    parameter int unsigned NCH         = 17,
    parameter int unsigned CW          = 16,
    parameter int unsigned GATE_MODE   = 0,
    parameter int unsigned GATE_CYCLES = 33000000,
    parameter int unsigned AW          = 6
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [NCH-1:0]      scal_i,
    input  logic                refpulse_i,
    input  logic                count_en_i,
    input  logic [AW-1:0]       scal_addr_i,
    input  logic                scal_rd_i,
    output logic [CW-1:0]       scal_dat_o,
    output logic                scal_valid_o,
    output logic [NCH-1:0]      ovf_o,
    output logic                update_o,
    output logic [15:0]         refpulse_cnt_o
);

    localparam int unsigned PW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [PW-1:0] PLAST = PW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] CMAX  = '1;

    logic [NCH-1:0] scal_q, scal_d;
    logic           ref_q, ref_d;
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [CW-1:0]  shadow_q [NCH];
    logic [CW-1:0]  shadow_d [NCH];
    logic [NCH-1:0] ovf_acc_q, ovf_acc_d;
    logic [NCH-1:0] ovf_q, ovf_d;
    logic [PW-1:0]  per_q, per_d;
    logic [15:0]    gcnt_q, gcnt_d;
    logic           upd_q, upd_d;
    logic [CW-1:0]  dat_q, dat_d;
    logic           vld_q, vld_d;
    logic [NCH-1:0] ev_c;
    logic           gate_c;

    // Counting, window latch and read mux; reads see the pre-latch shadow.
    always_comb begin
        ev_c      = scal_i & ~scal_q;
        gate_c    = (GATE_MODE != 0) ? (per_q == PLAST) : (refpulse_i & ~ref_q);
        scal_d    = scal_i;
        ref_d     = refpulse_i;
        per_d     = (per_q == PLAST) ? '0 : per_q + PW'(1);
        ovf_acc_d = ovf_acc_q;
        ovf_d     = ovf_q;
        gcnt_d    = gcnt_q;
        upd_d     = gate_c;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        vld_d     = scal_rd_i;
        dat_d     = dat_q;

        if (gate_c) begin
            gcnt_d    = gcnt_q + 16'd1;
            ovf_d     = ovf_acc_q;
            ovf_acc_d = '0;
        end

        for (int unsigned i = 0; i < NCH; i++) begin
            if (gate_c) begin
                shadow_d[i] = cnt_q[i];
                cnt_d[i]    = (count_en_i & ev_c[i]) ? CW'(1) : '0;
            end else if (count_en_i & ev_c[i]) begin
                if (cnt_q[i] != CMAX) begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end else begin
                    ovf_acc_d[i] = 1'b1;
                end
            end
        end

        if (scal_rd_i) begin
            dat_d = '0;
            if (scal_addr_i == AW'(NCH)) begin
                dat_d = CW'(gcnt_q);
            end
            for (int unsigned i = 0; i < NCH; i++) begin
                if (scal_addr_i == AW'(i)) begin
                    dat_d = shadow_q[i];
                end
            end
        end
    end

    // Edge registers reset high so a level already high at release is not an event.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scal_q    <= '1;
            ref_q     <= 1'b1;
            ovf_acc_q <= '0;
            ovf_q     <= '0;
            per_q     <= '0;
            gcnt_q    <= '0;
            upd_q     <= 1'b0;
            dat_q     <= '0;
            vld_q     <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            scal_q    <= scal_d;
            ref_q     <= ref_d;
            ovf_acc_q <= ovf_acc_d;
            ovf_q     <= ovf_d;
            per_q     <= per_d;
            gcnt_q    <= gcnt_d;
            upd_q     <= upd_d;
            dat_q     <= dat_d;
            vld_q     <= vld_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign scal_dat_o     = dat_q;
    assign scal_valid_o   = vld_q;
    assign ovf_o          = ovf_q;
    assign update_o       = upd_q;
    assign refpulse_cnt_o = gcnt_q;

endmodule

// File: doc/scaler_bank_v3.md
Name: scaler_bank_v3

Overview:
Parametrised successor to the 17-channel trigger scaler bank. It edge-counts NCH trigger-path inputs over a gate window. The window is closed either by the TURF reference pulse or by an internal period counter. At each window close it latches saturating counts and per-channel overflow flags into a shadow bank that MESS reads by address. The block sits between the Level-1 trigger scaler outputs (CR) and the MESS register interface, all on clk33.

Parameters:
NCH, 17, number of scaler channels (1..63)
CW, 16, counter/shadow width in bits
GATE_MODE, 0, 0 = window closed by refpulse_i rising edge; 1 = window closed every GATE_CYCLES clocks
GATE_CYCLES, 33000000, internal window length in clocks (GATE_MODE=1 only; >=2)
AW, 6, read address width; must satisfy 2^AW > NCH

Ports:
clk_i  in  1  system clock (clk33)
rst_n_i  in  1  asynchronous active-low reset
scal_i  in  NCH  trigger-path inputs, synchronous to clk_i, counted on rising edge
refpulse_i  in  1  TURF reference pulse, synchronous, rising edge = gate
count_en_i  in  1  1 = count events; 0 = counters hold (gates still latch)
scal_addr_i  in  AW  read address
scal_rd_i  in  1  read strobe, one cycle
scal_dat_o  out  CW  read data
scal_valid_o  out  1  read data valid pulse
ovf_o  out  NCH  overflow flags of latched bank
update_o  out  1  one-cycle pulse when shadow bank latched
refpulse_cnt_o  out  16  number of window closes since reset, wraps

Behaviour:
- Reset (async, rst_n_i=0): all outputs are 0. Counters, shadows, overflow flags, gate counter and internal period counter are 0. Edge registers (scal_q, ref_q) are all-ones, so a level held high at reset release produces no event.
- Event: ev[i] = scal_i[i] & ~scal_q[i]. gate = GATE_MODE ? (period counter == GATE_CYCLES-1) : (refpulse_i & ~ref_q).
- Period counter (mode 1): 0..GATE_CYCLES-1 and wraps. gate asserts on the wrap cycle, giving exactly one gate per GATE_CYCLES clocks.
- Normal cycle, no gate:
  - If count_en_i & ev[i] and cnt[i] < 2^CW-1: cnt[i]++.
  - If at max: cnt[i] holds and sticky ovf_acc[i] is set.
- Gate cycle t:
  - shadow[i] <= cnt[i] and ovf_o[i] <= ovf_acc[i], using pre-increment values.
  - cnt[i] <= (count_en_i & ev[i]) ? 1 : 0. A coincident event belongs to the new window.
  - ovf_acc cleared.
  - refpulse_cnt_o increments mod 2^16.
  - update_o = 1 in cycle t+1 only.
- Read: scal_rd_i at cycle t gives scal_dat_o and scal_valid_o=1 at t+1. scal_dat_o holds its value until the next read; scal_valid_o is a one-cycle pulse.
  - addr < NCH returns shadow[addr].
  - addr == NCH returns refpulse_cnt_o zero-extended or truncated to CW.
  - addr > NCH returns 0.
- Read and latch in the same cycle: the read returns the pre-latch shadow value.
- Back-to-back reads are allowed every cycle; each read returns its own address's data.
- count_en_i low: no increments and no new overflow. Gates still latch and clear, so the latched values are 0 unless events arrived with enable high.
- Reset mid-window discards the partial counts; the first bank after reset reflects only post-reset events.
- No flow control on reads. MESS must not issue a read while a previous read pulse is being consumed (single-cycle rule makes this moot).

Test Plan:
- Reset with scal_i all ones held -> no counts. Release scal_i and pulse ch0 5 times (2-cycle pulses), then a refpulse edge -> update_o pulse; read addr 0 gives 5 with valid one cycle after rd; addr 1 gives 0; ovf_o = 0.
- CW=4, 20 events on ch3 then a gate -> shadow[3]=15, ovf_o[3]=1. The next window has 2 events -> 2, ovf_o[3]=0.
- Event rising edge on ch2 coincident with a gate cycle, preceded by 7 events -> bank value 7; next window reads 1 after one more gate with no further events.
- GATE_MODE=1, GATE_CYCLES=100, run 1000 clocks -> exactly 10 update_o pulses spaced 100 clocks; addr NCH reads 10.
- Read addr 0 in the same cycle as a gate with old shadow=4 and new count 9 -> returns 4; the next read returns 9. Reads at addr NCH+1 return 0.
- Assert rst_n_i mid-window after 6 events and deassert -> all outputs 0 immediately. The first post-reset bank counts only post-reset events, and refpulse_cnt_o restarts at 0.
